// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard detection and forwarding controller for the in-order MIPS pipeline.
// A DEPTH-entry tag chain follows every instruction after decode (stage 0 = EX,
// stage DEPTH-1 = WB) and drives stalls, bubbles, the IF_ID flush and the EX
// forward selects.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-low reset
//   i_id_*                 decode-stage instruction fields
//   i_ext_stall            freeze the whole pipeline
//   o_pc_write             PC load enable
//   o_if_id_write          IF_ID load enable
//   o_if_id_flush          squash IF_ID on the next edge
//   o_bubble               select zero controls into ID_EX
//   o_fwd_a / o_fwd_b      EX operand source: 0 = register file, k = stage k result
//   o_stall_cnt, o_flush_cnt  saturating event counters (HAZ_PERF_CNT_EN only)
//
// Optional feature macro: HAZ_PERF_CNT_EN
module pipe_hazard_fwd_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  localparam int unsigned FW_W      = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_rs_used,
  input  logic              i_id_rt_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_branch,
  input  logic              i_id_taken,
  input  logic              i_ext_stall,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_bubble,
  output logic [FW_W-1:0]   o_fwd_a,
  output logic [FW_W-1:0]   o_fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       o_stall_cnt,
  output logic [15:0]       o_flush_cnt
`endif
);

  // Tag chain, bit/element k = stage k
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][REG_AW-1:0] r_rd;
  logic [DEPTH-1:0]             r_wr;
  logic [DEPTH-1:0]             r_mr;
  // Stage 0 source operands, needed for the forward selects
  logic [REG_AW-1:0]            r_rs;
  logic [REG_AW-1:0]            r_rt;
  logic                         r_rs_used;
  logic                         r_rt_used;

  logic [DEPTH-1:0] w_id_rs_hit;  // writer at stage k matches decode rs
  logic [DEPTH-1:0] w_id_rt_hit;
  logic [DEPTH-1:0] w_early;      // a load at stage k cannot yet be forwarded to the consumer
  logic [DEPTH-1:0] w_ex_a_hit;   // forwardable writer at stage k for stage 0 rs
  logic [DEPTH-1:0] w_ex_b_hit;
  logic             w_load_use;
  logic             w_branch_haz;
  logic             w_stall;
  logic [FW_W-1:0]  w_fwd_a;
  logic [FW_W-1:0]  w_fwd_b;

  always_comb begin
    w_id_rs_hit = '0;
    w_id_rt_hit = '0;
    w_early     = '0;
    w_ex_a_hit  = '0;
    w_ex_b_hit  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_id_rs_hit[k] = r_valid[k] && r_wr[k] && (r_rd[k] == i_id_rs) &&
                       (i_id_rs != '0) && i_id_rs_used;
      w_id_rt_hit[k] = r_valid[k] && r_wr[k] && (r_rd[k] == i_id_rt) &&
                       (i_id_rt != '0) && i_id_rt_used;
      w_early[k]     = (k + 1 < LOAD_READY);
      // Loads below LOAD_READY are skipped: the load-use stall keeps consumers away
      w_ex_a_hit[k]  = r_valid[k] && r_wr[k] && (r_rd[k] == r_rs) && (r_rs != '0) &&
                       !(r_mr[k] && (k < LOAD_READY));
      w_ex_b_hit[k]  = r_valid[k] && r_wr[k] && (r_rd[k] == r_rt) && (r_rt != '0) &&
                       !(r_mr[k] && (k < LOAD_READY));
    end
    w_load_use   = |((w_id_rs_hit | w_id_rt_hit) & r_mr & w_early);
    // No forwarding into ID, so a branch waits for every in-flight producer
    w_branch_haz = i_id_branch && |(w_id_rs_hit | w_id_rt_hit);
    w_stall      = i_id_valid && (w_load_use || w_branch_haz);
  end

  // Descending scan so the youngest (smallest k) producer is the last one written
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (r_valid[0] && r_rs_used && w_ex_a_hit[k]) w_fwd_a = FW_W'(k);
      if (r_valid[0] && r_rt_used && w_ex_b_hit[k]) w_fwd_b = FW_W'(k);
    end
  end

  always_comb begin
    o_pc_write    = 1'b1;
    o_if_id_write = 1'b1;
    o_if_id_flush = 1'b0;
    o_bubble      = 1'b0;
    o_fwd_a       = '0;
    o_fwd_b       = '0;
    if (i_rst) begin
      o_fwd_a = w_fwd_a;
      o_fwd_b = w_fwd_b;
      if (i_ext_stall) begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
      end else if (w_stall) begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_bubble      = 1'b1;
      end
      o_if_id_flush = i_id_valid && i_id_branch && i_id_taken && !w_stall && !i_ext_stall;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid   <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_mr      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rs_used <= 1'b0;
      r_rt_used <= 1'b0;
    end else if (!i_ext_stall) begin
      r_valid   <= {r_valid[DEPTH-2:0], i_id_valid && !w_stall};
      r_rd      <= {r_rd[DEPTH-2:0], i_id_rd};
      r_wr      <= {r_wr[DEPTH-2:0], i_id_reg_write};
      r_mr      <= {r_mr[DEPTH-2:0], i_id_mem_read};
      r_rs      <= i_id_rs;
      r_rt      <= i_id_rt;
      r_rs_used <= i_id_rs_used;
      r_rt_used <= i_id_rt_used;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !i_ext_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (o_if_id_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Self-checking bench for pipe_hazard_fwd_unit. Two instances (LOAD_READY=2 and
// LOAD_READY=1, DEPTH=3) share the decode inputs; each is compared every cycle
// against a queue-based model of in-flight instructions.
module tb_pipe_hazard_fwd_unit;
  localparam int D = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       mr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
  } instr_t;

  typedef struct packed {
    logic       stall;
    logic       pcw;
    logic       ifw;
    logic       flush;
    logic       bubble;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       skip;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
  logic       id_branch, id_taken, ext;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] pcw, ifw, flush, bubble;
  logic [1:0][1:0] fa, fb;
`ifdef HAZ_PERF_CNT_EN
  logic [1:0][15:0] scnt, fcnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic hold = 1'b0;
  instr_t ch0[$], ch1[$];
  int exp_scnt[2], exp_fcnt[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_hazard_fwd_unit #(.REG_AW(5), .DEPTH(D), .LOAD_READY(2 - g)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used), .i_id_rd(id_rd),
      .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read), .i_id_branch(id_branch),
      .i_id_taken(id_taken), .i_ext_stall(ext), .o_pc_write(pcw[g]),
      .o_if_id_write(ifw[g]), .o_if_id_flush(flush[g]), .o_bubble(bubble[g]),
      .o_fwd_a(fa[g]), .o_fwd_b(fb[g])
`ifdef HAZ_PERF_CNT_EN
      , .o_stall_cnt(scnt[g]), .o_flush_cnt(fcnt[g])
`endif
    );
  end

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, want);
  endtask

  function automatic logic writes(input instr_t e, input logic [4:0] r);
    return e.v && e.wr && (e.rd == r) && (r != 5'd0);
  endfunction

  function automatic exp_t model_eval(input instr_t ch[$], input int lr);
    exp_t e;
    logic lu, hit;
    e = '0;
    e.pcw = 1'b1;
    e.ifw = 1'b1;
    if (!rst) return e;
    lu = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < D; k++) begin
      if ((id_rs_used && writes(ch[k], id_rs)) || (id_rt_used && writes(ch[k], id_rt))) begin
        hit = 1'b1;
        // consumer would reach EX with the load at k+1, too early if below lr
        if (ch[k].mr && (k + 1 < lr)) lu = 1'b1;
      end
    end
    e.stall = id_valid && (lu || (id_branch && hit));
    if (ext) begin
      e.pcw = 1'b0;
      e.ifw = 1'b0;
    end else if (e.stall) begin
      e.pcw = 1'b0;
      e.ifw = 1'b0;
      e.bubble = 1'b1;
    end
    e.flush = id_valid && id_branch && id_taken && !e.stall && !ext;
    if (ch[0].v && ch[0].rsu) begin
      for (int k = 1; k < D; k++) begin
        if (writes(ch[k], ch[0].rs)) begin
          if (ch[k].mr && k < lr) e.skip = 1'b1;
          else begin
            e.fa = 2'(k);
            break;
          end
        end
      end
    end
    if (ch[0].v && ch[0].rtu) begin
      for (int k = 1; k < D; k++) begin
        if (writes(ch[k], ch[0].rt)) begin
          if (ch[k].mr && k < lr) e.skip = 1'b1;
          else begin
            e.fb = 2'(k);
            break;
          end
        end
      end
    end
    return e;
  endfunction

  function automatic instr_t id_instr(input logic stall);
    instr_t x;
    x.v = id_valid && !stall;
    x.rd = id_rd;
    x.wr = id_reg_write;
    x.mr = id_mem_read;
    x.rs = id_rs;
    x.rt = id_rt;
    x.rsu = id_rs_used;
    x.rtu = id_rt_used;
    return x;
  endfunction

  task automatic clear_models();
    ch0.delete();
    ch1.delete();
    for (int k = 0; k < D; k++) begin
      ch0.push_back('0);
      ch1.push_back('0);
    end
    exp_scnt = '{0, 0};
    exp_fcnt = '{0, 0};
  endtask

  // One clock: compare at negedge, advance models at posedge, return at posedge+1
  task automatic step();
    exp_t e[2];
    @(negedge clk);
    e[0] = model_eval(ch0, 2);
    e[1] = model_eval(ch1, 1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pc_write%0d", i), int'(pcw[i]), int'(e[i].pcw));
      check($sformatf("if_id_write%0d", i), int'(ifw[i]), int'(e[i].ifw));
      check($sformatf("if_id_flush%0d", i), int'(flush[i]), int'(e[i].flush));
      check($sformatf("bubble%0d", i), int'(bubble[i]), int'(e[i].bubble));
      check($sformatf("fwd_a%0d", i), int'(fa[i]), int'(e[i].fa));
      check($sformatf("fwd_b%0d", i), int'(fb[i]), int'(e[i].fb));
      if (e[i].skip) check($sformatf("ld_skip%0d", i), 1, 0);
`ifdef HAZ_PERF_CNT_EN
      check($sformatf("stall_cnt%0d", i), int'(scnt[i]), exp_scnt[i]);
      check($sformatf("flush_cnt%0d", i), int'(fcnt[i]), exp_fcnt[i]);
`endif
    end
    hold = rst && (e[0].stall || ext);
    @(posedge clk);
    if (!rst) clear_models();
    else begin
      for (int i = 0; i < 2; i++) begin
        if (e[i].stall && !ext && exp_scnt[i] < 16'hFFFF) exp_scnt[i]++;
        if (e[i].flush && exp_fcnt[i] < 16'hFFFF) exp_fcnt[i]++;
      end
      if (!ext) begin
        ch0.push_front(id_instr(e[0].stall));
        void'(ch0.pop_back());
        ch1.push_front(id_instr(e[1].stall));
        void'(ch1.pop_back());
      end
    end
    #1;
    cyc++;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] rd, input logic wr, input logic mr,
                       input logic br, input logic tk);
    id_valid = v;
    id_rs = rs;
    id_rs_used = rsu;
    id_rt = rt;
    id_rt_used = rtu;
    id_rd = rd;
    id_reg_write = wr;
    id_mem_read = mr;
    id_branch = br;
    id_taken = tk;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (D + 1) step();
  endtask

  initial begin
    clear_models();
    ext = 1'b0;
    // Reset with every chain input active
    rst = 1'b0;
    issue(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) begin
      #1;
      check("rst_pc_write", int'(pcw[0]), 1);
      check("rst_bubble", int'(bubble[0]), 0);
      check("rst_fwd_a", int'(fa[0]), 0);
      check("rst_fwd_b", int'(fb[0]), 0);
      step();
    end
    rst = 1'b1;
    issue(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("post_rst_no_stall", int'(pcw[0]), 1);
    check("post_rst_fwd_a", int'(fa[0]), 0);
    step();
    drain();

    // Back-to-back ALU writers
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); step();
    issue(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); step();
    nop(); #1; check("fwd_adjacent", int'(fa[0]), 1); step();
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); step();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); step();
    issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); step();
    nop(); #1; check("fwd_gap1", int'(fa[0]), 2); step();
    drain();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); step();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); step();
    issue(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); step();
    nop(); #1; check("fwd_youngest_b", int'(fb[0]), 1); step();
    drain();

    // Load-use
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); step();
    issue(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_pc_write", int'(pcw[0]), 0);
    check("lu_if_id_write", int'(ifw[0]), 0);
    check("lu_bubble", int'(bubble[0]), 1);
    check("lu_lr1_no_stall", int'(pcw[1]), 1);
    step();
    #1; check("lu_release", int'(pcw[0]), 1); step();
    nop(); #1; check("lu_fwd_a", int'(fa[0]), 2); step();
    drain();

    // Register $0 never forwards or stalls
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); step();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1; check("r0_no_stall", int'(pcw[0]), 1); step();
    nop(); #1; check("r0_no_fwd", int'(fa[0]), 0); step();
    drain();

    // Branch waits for the producer to leave the chain, flushes on release
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); step();
    issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      #1;
      check("br_stall", int'(pcw[0]), 0);
      check("br_no_flush", int'(flush[0]), 0);
      step();
    end
    #1;
    check("br_release", int'(pcw[0]), 1);
    check("br_flush", int'(flush[0]), 1);
    step();
    nop(); #1; check("br_flush_once", int'(flush[0]), 0); step();
    drain();

    // Freeze during a pending load-use stall
    rst = 1'b0; step(); rst = 1'b1;
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); step();
    issue(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    ext = 1'b1;
    repeat (4) begin
      #1;
      check("frz_bubble", int'(bubble[0]), 0);
      check("frz_pc_write", int'(pcw[0]), 0);
      step();
    end
    ext = 1'b0;
    #1; check("frz_resume_bubble", int'(bubble[0]), 1); step();
    #1; check("frz_resume_go", int'(pcw[0]), 1);
`ifdef HAZ_PERF_CNT_EN
    check("frz_stall_cnt", int'(scnt[0]), 1);
`endif
    step();
    drain();

    // Randomized traffic; decode holds its instruction while stalled or frozen
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      ext = ($urandom_range(0, 9) == 0);
      if (!hold) begin
        id_valid = ($urandom_range(0, 3) != 0);
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_rs_used = 1'($urandom_range(0, 1));
        id_rt_used = 1'($urandom_range(0, 1));
        id_branch = ($urandom_range(0, 4) == 0);
        id_taken = 1'($urandom_range(0, 1));
        id_reg_write = !id_branch && ($urandom_range(0, 3) != 0);
        id_mem_read = id_reg_write && ($urandom_range(0, 2) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_fwd_unit.md
Name: pipe_hazard_fwd_unit

Overview:
Parametrised hazard detection and forwarding controller for the in-order MIPS pipeline. It replaces fixed-depth hazard and forwarding logic with a tag chain of DEPTH in-flight stages after decode. Stage 0 is EX; stage DEPTH-1 is WB. The block drives the PC/IF_ID write enables, the IF_ID flush, the control-bubble mux select and the EX-stage forward selects. It adds load-latency parametrisation, an external freeze input and branch-operand stalls.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, number of tracked post-decode stages (EX..WB); legal range 2..8
LOAD_READY, 2, first stage index at which load data can be forwarded; legal range 1..DEPTH-1
FW_W, $clog2(DEPTH), forward-select width (derived; not overridable)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-low reset
id_valid  in  1  IF_ID holds a real instruction
id_rs  in  REG_AW  decode source register 1
id_rt  in  REG_AW  decode source register 2
id_rs_used  in  1  decode instruction reads rs
id_rt_used  in  1  decode instruction reads rt
id_rd  in  REG_AW  decode destination (already reg_dst-resolved)
id_reg_write  in  1  decode instruction writes a register
id_mem_read  in  1  decode instruction is a load
id_branch  in  1  decode instruction is a branch (compared in ID)
id_taken  in  1  branch comparator result (valid with id_branch)
ext_stall  in  1  freeze the whole pipeline (memory wait)
pc_write  out  1  PC load enable
if_id_write  out  1  IF_ID load enable
if_id_flush  out  1  squash IF_ID on next edge
bubble  out  1  select zero controls into ID_EX (mux_hz_sel)
fwd_a  out  FW_W  EX operand A source: 0 = register file, k = stage k result
fwd_b  out  FW_W  EX operand B source, same encoding

Behaviour:
- State per stage k: valid, rd, reg_write, mem_read. Stage 0 also holds rs, rt, rs_used and rt_used.
- Synchronous reset (rst==0 at edge): all valid bits cleared, and optional counters cleared.
- Outputs during and after reset: pc_write=1, if_id_write=1, if_id_flush=0, bubble=0, fwd_a=fwd_b=0.
- Writer match at stage k for register r: valid[k] && reg_write[k] && rd[k]==r && r!=0.
- Load-use stall: for a used source r, a load matches r at stage k with k+1 < LOAD_READY.
- Branch stall: id_branch with any used source r matched by any writer at stages 0..DEPTH-1. There is no forwarding into ID.
- stall = id_valid && (load-use stall || branch stall).
- ext_stall=1:
  - Chain does not shift; stage contents are held.
  - pc_write=0, if_id_write=0, bubble=0, if_id_flush=0.
  - fwd outputs remain combinationally valid.
- stall=1 with ext_stall=0:
  - pc_write=0, if_id_write=0, bubble=1.
  - Chain shifts; stage 0 loads valid=0.
- Normal cycle:
  - pc_write=1, if_id_write=1, bubble=0.
  - Chain shifts; stage 0 loads the ID fields with valid=id_valid.
- Shift: stage k+1 <= stage k; stage DEPTH-1 contents are discarded.
- if_id_flush = id_valid && id_branch && id_taken && !stall && !ext_stall. A stalled taken branch flushes only in the cycle it is released. The branch itself enters stage 0.
- Forward selects: fwd_a is the smallest k in 1..DEPTH-1 with a writer match on stage-0 rs, provided stage 0 is valid and rs_used. Otherwise fwd_a=0.
- A matching load at k < LOAD_READY is skipped and search continues, because the load-use stall guarantees the consumer is never there. The bench asserts this never happens.
- fwd_b uses the same rule on rt.
- Youngest producer wins when several stages match.
- All outputs are combinational from state plus ID inputs. There is no added latency; decisions apply to the current cycle.
- ext_stall and stall together: ext_stall dominates and no bubble is inserted.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each cycle stall && !ext_stall.
  - flush_cnt increments each cycle if_id_flush==1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with all chain inputs active -> pc_write=1, bubble=0, fwd_a=fwd_b=0; after release, stage 0 is empty.
- Back-to-back ALU writes: add $3 then sub uses $3 as rs -> fwd_a=1. With one unrelated instruction between them -> fwd_a=2. With two older writers of $3 -> fwd_a=1.
- Load-use (DEPTH=3, LOAD_READY=2): lw $5 then add rs=$5 -> exactly one cycle of pc_write=0, if_id_write=0, bubble=1, then fwd_a=2. Repeat with LOAD_READY=1 -> no stall.
- Register $0: writer rd=0 followed by a reader of $0 -> no forward, no stall.
- Branch: beq on $4 issued right after add $4 (DEPTH=3) -> 3 stall cycles. Then id_taken=1 -> if_id_flush=1 for one cycle only after release.
- Freeze: ext_stall=1 for 4 cycles during a pending load-use stall -> chain frozen, bubble=0. Resume -> the single required stall cycle occurs. With HAZ_PERF_CNT_EN, stall_cnt=1.
